// File: rtl/cpu_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_irq_ctrl_if
//   Avalon-MM 16-bit register bus between the CPU_0 data master and the
//   interrupt controller.
//   Signals:
//     address    [2:0]   word address of the register
//     chipselect         slave select
//     write_n            active-low write strobe, valid with chipselect
//     writedata  [15:0]  write data
//     readdata   [15:0]  registered read data returned by the slave
//   Modports: master (CPU side), slave (controller side).
// ---------------------------------------------------------------------------
interface cpu_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_irq_ctrl
//   Collects up to 16 peripheral interrupt lines (interval timer on line 0)
//   and presents one registered interrupt to the CPU. Registers: PENDING,
//   MASK, EDGE_SEL, ACTIVE_ID (lowest pending&mask index wins), SW_SET.
//
//   Optional feature macro: IRQ_CTRL_EDGE_MODE_EN
//     defined     - per-line rising-edge capture selectable through EDGE_SEL,
//                   PENDING write-1-to-clear and SW_SET act on edge lines.
//     not defined - every line is level-sensitive, EDGE_SEL reads 0,
//                   PENDING writes and SW_SET have no effect.
//
//   Ports:
//     clk      system clock, all logic on posedge
//     reset_n  asynchronous active-low reset
//     bus      cpu_irq_ctrl_if.slave register bus (1-cycle read latency,
//              readdata follows address every cycle)
//     irq_in   [NUM_IRQ-1:0] active-high requests, bit 0 highest priority
//     irq      registered interrupt to the CPU
// ---------------------------------------------------------------------------
module cpu_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  cpu_irq_ctrl_if.slave      bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] ADDR_PENDING   = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL  = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
  localparam logic [2:0] ADDR_SW_SET    = 3'd4;

  // Zero-extend a line vector to the 16-bit bus width.
  function automatic logic [15:0] widen(input logic [NUM_IRQ-1:0] v);
    logic [15:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] wdata_irq;
  logic               wr_en;
  logic               unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata_irq    = bus.writedata[NUM_IRQ-1:0];
  // Upper writedata bits are intentionally ignored for narrow configurations.
  assign unused_wdata = ^bus.writedata;

  // ---- stage p0: optional input synchroniser ----
  if (SYNC_STAGES == 0) begin : g_nosync
    assign irq_s = irq_in;
  end else begin : g_sync
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign irq_s = sync_q[SYNC_STAGES-1];
  end

  // ---- stage p1: pending capture ----
`ifdef IRQ_CTRL_EDGE_MODE_EN
  logic [NUM_IRQ-1:0] edge_sel_q;
  logic [NUM_IRQ-1:0] irq_d_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] set;

  // irq_d resets to 0, so a line already high at reset release is seen as a
  // rise one cycle later; this guarantees the timer event is never lost.
  assign rise = irq_s & ~irq_d_q;
  assign clr  = (wr_en && bus.address == ADDR_PENDING) ? wdata_irq : '0;
  assign set  = (wr_en && bus.address == ADDR_SW_SET)  ? wdata_irq : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_q <= '0;
      irq_d_q    <= '0;
      pend_q     <= '0;
    end else begin
      irq_d_q <= irq_s;
      if (wr_en && bus.address == ADDR_EDGE_SEL) edge_sel_q <= wdata_irq;
      // Edge lines: set applied after clear so a coincident event survives.
      // Level lines: track irq_s so a level->edge switch starts from the
      // line's current value.
      pend_q <= (edge_sel_q & ((pend_q & ~clr) | rise | set)) |
                (~edge_sel_q & irq_s);
    end
  end

  assign edge_sel = edge_sel_q;
  assign pending  = (edge_sel_q & pend_q) | (~edge_sel_q & irq_s);
`else
  assign edge_sel = '0;
  assign pending  = irq_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (wr_en && bus.address == ADDR_MASK) begin
      mask_q <= wdata_irq;
    end
  end

  // Fixed priority: lowest index of pending & mask.
  logic [NUM_IRQ-1:0] pm;
  logic               act_valid;
  logic [3:0]         act_id;

  always_comb begin
    pm        = pending & mask_q;
    act_valid = |pm;
    act_id    = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pm[i]) act_id = 4'(i);
    end
  end

  // ---- stage p2: registered outputs ----
  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.address)
      ADDR_PENDING:   rd_mux = widen(pending);
      ADDR_MASK:      rd_mux = widen(mask_q);
      ADDR_EDGE_SEL:  rd_mux = widen(edge_sel);
      ADDR_ACTIVE_ID: rd_mux = {act_valid, 11'b0, act_id};
      default:        rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 16'h0000;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      irq          <= act_valid;
    end
  end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_irq_ctrl
//   Self-checking bench for cpu_irq_ctrl (NUM_IRQ=8, SYNC_STAGES=0).
//   Each step drives one bus cycle plus irq_in, queues the expected readdata
//   and irq, and after the next rising edge pops and compares them.
//   Edge-mode sequences run when IRQ_CTRL_EDGE_MODE_EN is defined; otherwise
//   the disabled-feature behaviour is checked.
// ---------------------------------------------------------------------------
module tb_cpu_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq;

  cpu_irq_ctrl_if bus ();

  cpu_irq_ctrl #(
    .NUM_IRQ    (8),
    .SYNC_STAGES(0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .irq_in (irq_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [15:0] exp;
    bit          is_irq;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic        cs;
    logic [2:0]  a;
    logic        wr;
    logic [15:0] wd;
    logic [7:0]  ii;
    logic [15:0] erd;
    logic        eirq;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle, push expectations, compare after the edge.
  task automatic step(input logic cs, input logic [2:0] a, input logic wr,
                      input logic [15:0] wd, input logic [7:0] ii,
                      input logic [15:0] erd, input logic eirq, input string nm);
    sb_t e;
    bus.chipselect = cs;
    bus.address    = a;
    bus.write_n    = ~wr;
    bus.writedata  = wd;
    irq_in         = ii;
    sbq.push_back('{name: {nm, "_rd"}, exp: erd, is_irq: 1'b0});
    sbq.push_back('{name: {nm, "_irq"}, exp: {15'b0, eirq}, is_irq: 1'b1});
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.is_irq) chk(e.name, {15'b0, irq}, e.exp);
      else          chk(e.name, bus.readdata, e.exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n        = 1'b0;
    irq_in         = 8'h00;
    bus.chipselect = 1'b0;
    bus.address    = 3'd0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0000;

    // Level-mode table, starting from reset state with mask 0.
    tbl[0]  = '{1'b1, 3'd1, 1'b1, 16'h0001, 8'h00, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 1'b0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[2]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h01, 16'h8000, 1'b1};
    tbl[3]  = '{1'b1, 3'd0, 1'b1, 16'h0001, 8'h01, 16'h0001, 1'b1};
    tbl[4]  = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[5]  = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 3'd4, 1'b1, 16'h00FF, 8'h00, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 3'd1, 1'b1, 16'h00F0, 8'h00, 16'h0001, 1'b0};
    tbl[10] = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h30, 16'h0030, 1'b1};
    tbl[11] = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h30, 16'h8004, 1'b1};
    tbl[12] = '{1'b1, 3'd1, 1'b1, 16'hFFFF, 8'h30, 16'h00F0, 1'b1};
    tbl[13] = '{1'b1, 3'd1, 1'b0, 16'h0000, 8'h06, 16'h00FF, 1'b1};
    tbl[14] = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h06, 16'h8001, 1'b1};
    tbl[15] = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'h06, 16'h0000, 1'b1};
    tbl[16] = '{1'b1, 3'd6, 1'b1, 16'hFFFF, 8'h00, 16'h0000, 1'b0};
    tbl[17] = '{1'b0, 3'd7, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0};
    tbl[18] = '{1'b0, 3'd1, 1'b1, 16'h0000, 8'h00, 16'h00FF, 1'b0};
    tbl[19] = '{1'b1, 3'd1, 1'b0, 16'h0000, 8'h00, 16'h00FF, 1'b0};
    tbl[20] = '{1'b1, 3'd1, 1'b1, 16'h0000, 8'h00, 16'h00FF, 1'b0};
    tbl[21] = '{1'b1, 3'd1, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", bus.readdata, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1;

    // Activity, then reset mid-run with all lines high
    step(1'b1, 3'd1, 1'b1, 16'h00FF, 8'hFF, 16'h0000, 1'b0, "pre_mask");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'hFF, 16'h00FF, 1'b1, "pre_pend");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd", bus.readdata, 16'h0000);
    chk("async_rst_irq", {15'b0, irq}, 16'h0000);
    @(posedge clk);
    #1;
    chk("held_rst_rd", bus.readdata, 16'h0000);
    chk("held_rst_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1;
    step(1'b1, 3'd1, 1'b0, 16'h0000, 8'hFF, 16'h0000, 1'b0, "post_mask");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'hFF, 16'h00FF, 1'b0, "post_pend");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "post_clr");

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].cs, tbl[i].a, tbl[i].wr, tbl[i].wd, tbl[i].ii,
           tbl[i].erd, tbl[i].eirq, $sformatf("lvl%0d", i));
    end

`ifdef IRQ_CTRL_EDGE_MODE_EN
    // Edge capture of a single-cycle pulse, then W1C
    step(1'b1, 3'd2, 1'b1, 16'h0004, 8'h00, 16'h0000, 1'b0, "e_sel");
    step(1'b1, 3'd1, 1'b1, 16'h0004, 8'h00, 16'h0000, 1'b0, "e_mask");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0, "e_pulse");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0004, 1'b1, "e_pend");
    step(1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 16'h8002, 1'b1, "e_id");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0004, 1'b1, "e_hold");
    step(1'b1, 3'd0, 1'b1, 16'h0004, 8'h00, 16'h0004, 1'b1, "e_w1c");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "e_cleared");
    // W1C coinciding with a new rise: set wins
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0, "c_rise1");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0004, 1'b1, "c_pend");
    step(1'b1, 3'd0, 1'b1, 16'h0004, 8'h04, 16'h0004, 1'b1, "c_collide");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0004, 1'b1, "c_kept");
    step(1'b1, 3'd0, 1'b1, 16'h0004, 8'h00, 16'h0004, 1'b1, "c_w1c");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "c_clr");
    // Line held high: one rise only, cleared while still high
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0, "h_rise");
    step(1'b1, 3'd0, 1'b1, 16'h0004, 8'h04, 16'h0004, 1'b1, "h_w1c");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0, "h_high");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "h_low");
    // Priority with software set; masked line still latches
    step(1'b1, 3'd2, 1'b1, 16'h00FF, 8'h00, 16'h0004, 1'b0, "p_sel");
    step(1'b1, 3'd1, 1'b1, 16'h00A0, 8'h00, 16'h0004, 1'b0, "p_mask");
    step(1'b1, 3'd4, 1'b1, 16'h00A2, 8'h00, 16'h0000, 1'b0, "p_swset");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h00A2, 1'b1, "p_pend");
    step(1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 16'h8005, 1'b1, "p_id5");
    step(1'b1, 3'd0, 1'b1, 16'h0020, 8'h00, 16'h00A2, 1'b1, "p_clr5");
    step(1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 16'h8007, 1'b1, "p_id7");
    step(1'b1, 3'd0, 1'b1, 16'h0080, 8'h00, 16'h0082, 1'b1, "p_clr7");
    step(1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "p_idnone");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0002, 1'b0, "p_masked");
    // Edge -> level: pending follows the (low) input from the next cycle
    step(1'b1, 3'd2, 1'b1, 16'h0000, 8'h00, 16'h00FF, 1'b0, "s_lvl");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "s_track");
`else
    // Feature disabled: EDGE_SEL and SW_SET inert
    step(1'b1, 3'd2, 1'b1, 16'hFFFF, 8'h00, 16'h0000, 1'b0, "d_sel_wr");
    step(1'b1, 3'd2, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "d_sel_rd");
    step(1'b1, 3'd1, 1'b1, 16'h0001, 8'h00, 16'h0000, 1'b0, "d_mask");
    step(1'b1, 3'd4, 1'b1, 16'h0001, 8'h00, 16'h0000, 1'b0, "d_swset");
    step(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "d_pend");
    step(1'b1, 3'd6, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, "d_addr6");
    step(1'b1, 3'd1, 1'b0, 16'h0000, 8'h01, 16'h0001, 1'b1, "d_lvl_irq");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
